// File: rtl/rf_exe_pipe.sv
// Register-read to exe1 pipeline register pair with load-use bubbling and intra-pair RAW splitting.
// Optional load-use bubble counter enabled by defining RF_EXE_STALL_CNT_EN.
module rf_exe_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        eu0_valid,
    input  logic        eu1_valid,
    output logic        in_ready,
    input  logic [4:0]  eu0_rj,
    input  logic [4:0]  eu0_rk,
    input  logic [4:0]  eu0_rd,
    input  logic [4:0]  eu1_rj,
    input  logic [4:0]  eu1_rk,
    input  logic [4:0]  eu1_rd,
    input  logic        eu0_en,
    input  logic        eu1_en,
    input  logic        eu0_load,
    input  logic        eu1_load,
    input  logic [31:0] data00,
    input  logic [31:0] data01,
    input  logic [31:0] data10,
    input  logic [31:0] data11,
    output logic        out_eu0_valid,
    output logic        out_eu1_valid,
    output logic [4:0]  out_eu0_rj,
    output logic [4:0]  out_eu0_rk,
    output logic [4:0]  out_eu0_rd,
    output logic [4:0]  out_eu1_rj,
    output logic [4:0]  out_eu1_rk,
    output logic [4:0]  out_eu1_rd,
    output logic        out_eu0_en,
    output logic        out_eu1_en,
    output logic        out_eu0_load,
    output logic        out_eu1_load,
    output logic [31:0] out_data00,
    output logic [31:0] out_data01,
    output logic [31:0] out_data10,
    output logic [31:0] out_data11,
    input  logic        out_ready
`ifdef RF_EXE_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic {
        NORM  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    typedef struct packed {
        logic        v;
        logic [4:0]  rj;
        logic [4:0]  rk;
        logic [4:0]  rd;
        logic        en;
        logic        ld;
        logic [31:0] da;
        logic [31:0] db;
    } lane_t;

    state_e state_q, state_d;
    lane_t  l0_q, l1_q, l0_d, l1_d;
    lane_t  in0, in1;
    logic   advance, load_use, intra, src0_hit, src1_hit;

    function automatic logic hit(input logic [4:0] r, input lane_t l);
        return l.v && l.en && l.ld && (l.rd != 5'd0) && (r == l.rd);
    endfunction

    always_comb begin
        in0 = '{v: eu0_valid, rj: eu0_rj, rk: eu0_rk, rd: eu0_rd, en: eu0_en, ld: eu0_load,
                da: data00, db: data01};
        in1 = '{v: eu1_valid, rj: eu1_rj, rk: eu1_rk, rd: eu1_rd, en: eu1_en, ld: eu1_load,
                da: data10, db: data11};
    end

    always_comb begin
        advance  = (!l0_q.v && !l1_q.v) || out_ready;
        src0_hit = eu0_valid && (hit(eu0_rj, l0_q) || hit(eu0_rj, l1_q) ||
                                 hit(eu0_rk, l0_q) || hit(eu0_rk, l1_q));
        src1_hit = eu1_valid && (hit(eu1_rj, l0_q) || hit(eu1_rj, l1_q) ||
                                 hit(eu1_rk, l0_q) || hit(eu1_rk, l1_q));
        // While splitting, lane0 has already left; only lane1 sources can still stall.
        load_use = (state_q == SPLIT) ? src1_hit : (src0_hit || src1_hit);
        intra    = eu0_valid && eu1_valid && eu0_en && (eu0_rd != 5'd0) &&
                   ((eu1_rj == eu0_rd) || (eu1_rk == eu0_rd));
    end

    always_comb begin
        state_d  = state_q;
        l0_d     = l0_q;
        l1_d     = l1_q;
        in_ready = 1'b0;
        if (advance) begin
            if (load_use) begin
                l0_d.v = 1'b0;
                l1_d.v = 1'b0;
            end else if (state_q == SPLIT) begin
                l0_d.v   = 1'b0;
                l1_d     = in1;
                in_ready = eu0_valid || eu1_valid;
                state_d  = NORM;
            end else if (intra) begin
                l0_d    = in0;
                l1_d.v  = 1'b0;
                state_d = SPLIT;
            end else begin
                l0_d     = in0;
                l1_d     = in1;
                in_ready = eu0_valid || eu1_valid;
            end
        end
        if (flush) begin
            l0_d.v   = 1'b0;
            l1_d.v   = 1'b0;
            state_d  = NORM;
            in_ready = 1'b0;
        end
        if (rst) begin
            in_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NORM;
            l0_q    <= '0;
            l1_q    <= '0;
        end else begin
            state_q <= state_d;
            l0_q    <= l0_d;
            l1_q    <= l1_d;
        end
    end

    assign out_eu0_valid = l0_q.v;
    assign out_eu0_rj    = l0_q.rj;
    assign out_eu0_rk    = l0_q.rk;
    assign out_eu0_rd    = l0_q.rd;
    assign out_eu0_en    = l0_q.en;
    assign out_eu0_load  = l0_q.ld;
    assign out_data00    = l0_q.da;
    assign out_data01    = l0_q.db;
    assign out_eu1_valid = l1_q.v;
    assign out_eu1_rj    = l1_q.rj;
    assign out_eu1_rk    = l1_q.rk;
    assign out_eu1_rd    = l1_q.rd;
    assign out_eu1_en    = l1_q.en;
    assign out_eu1_load  = l1_q.ld;
    assign out_data10    = l1_q.da;
    assign out_data11    = l1_q.db;

`ifdef RF_EXE_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic        bubble;

    assign bubble = advance && load_use && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (bubble) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rf_exe_pipe.sv
// Randomized bench for rf_exe_pipe against an issue-mask reference model of the held pair.
// Define RF_EXE_STALL_CNT_EN to also check the bubble counter.
module tb_rf_exe_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, out_ready;
    logic        eu0_valid, eu1_valid, in_ready;
    logic [4:0]  eu0_rj, eu0_rk, eu0_rd, eu1_rj, eu1_rk, eu1_rd;
    logic        eu0_en, eu1_en, eu0_load, eu1_load;
    logic [31:0] data00, data01, data10, data11;
    logic        out_eu0_valid, out_eu1_valid;
    logic [4:0]  out_eu0_rj, out_eu0_rk, out_eu0_rd, out_eu1_rj, out_eu1_rk, out_eu1_rd;
    logic        out_eu0_en, out_eu1_en, out_eu0_load, out_eu1_load;
    logic [31:0] out_data00, out_data01, out_data10, out_data11;
`ifdef RF_EXE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    rf_exe_pipe dut (
        .clk(clk), .rst(rst), .flush(flush),
        .eu0_valid(eu0_valid), .eu1_valid(eu1_valid), .in_ready(in_ready),
        .eu0_rj(eu0_rj), .eu0_rk(eu0_rk), .eu0_rd(eu0_rd),
        .eu1_rj(eu1_rj), .eu1_rk(eu1_rk), .eu1_rd(eu1_rd),
        .eu0_en(eu0_en), .eu1_en(eu1_en), .eu0_load(eu0_load), .eu1_load(eu1_load),
        .data00(data00), .data01(data01), .data10(data10), .data11(data11),
        .out_eu0_valid(out_eu0_valid), .out_eu1_valid(out_eu1_valid),
        .out_eu0_rj(out_eu0_rj), .out_eu0_rk(out_eu0_rk), .out_eu0_rd(out_eu0_rd),
        .out_eu1_rj(out_eu1_rj), .out_eu1_rk(out_eu1_rk), .out_eu1_rd(out_eu1_rd),
        .out_eu0_en(out_eu0_en), .out_eu1_en(out_eu1_en),
        .out_eu0_load(out_eu0_load), .out_eu1_load(out_eu1_load),
        .out_data00(out_data00), .out_data01(out_data01),
        .out_data10(out_data10), .out_data11(out_data11),
        .out_ready(out_ready)
`ifdef RF_EXE_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit        v;
        bit [4:0]  rj;
        bit [4:0]  rk;
        bit [4:0]  rd;
        bit        en;
        bit        ld;
        bit [31:0] a;
        bit [31:0] b;
    } mlane_t;

    mlane_t      in_l [2];
    mlane_t      m_out[2];
    bit          m_rest;
    int unsigned m_cnt;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mlane_t mk(input bit v, input bit [4:0] rj, input bit [4:0] rk,
                                  input bit [4:0] rd, input bit en, input bit ld);
        mlane_t l;
        l.v = v; l.rj = rj; l.rk = rk; l.rd = rd; l.en = en; l.ld = ld;
        l.a = $urandom; l.b = $urandom;
        return l;
    endfunction

    function automatic mlane_t rnd_lane();
        return mk($urandom_range(0, 4) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
    endfunction

    // A source register waits on any held, valid, writing load whose rd is that (nonzero) register.
    function automatic bit waits_on_load(input bit [4:0] r);
        bit w = 1'b0;
        for (int l = 0; l < 2; l++)
            if (m_out[l].v && m_out[l].en && m_out[l].ld && m_out[l].rd != 5'd0 && m_out[l].rd == r)
                w = 1'b1;
        return w;
    endfunction

    task automatic drive();
        eu0_valid = in_l[0].v; eu0_rj = in_l[0].rj; eu0_rk = in_l[0].rk; eu0_rd = in_l[0].rd;
        eu0_en = in_l[0].en; eu0_load = in_l[0].ld; data00 = in_l[0].a; data01 = in_l[0].b;
        eu1_valid = in_l[1].v; eu1_rj = in_l[1].rj; eu1_rk = in_l[1].rk; eu1_rd = in_l[1].rd;
        eu1_en = in_l[1].en; eu1_load = in_l[1].ld; data10 = in_l[1].a; data11 = in_l[1].b;
    endtask

    task automatic check_outputs();
        check("v0", out_eu0_valid, m_out[0].v);
        check("v1", out_eu1_valid, m_out[1].v);
        if (m_out[0].v) begin
            check("l0_ctl", {out_eu0_rj, out_eu0_rk, out_eu0_rd, out_eu0_en, out_eu0_load},
                  {m_out[0].rj, m_out[0].rk, m_out[0].rd, m_out[0].en, m_out[0].ld});
            check("l0_data", {out_data00, out_data01}, {m_out[0].a, m_out[0].b});
        end
        if (m_out[1].v) begin
            check("l1_ctl", {out_eu1_rj, out_eu1_rk, out_eu1_rd, out_eu1_en, out_eu1_load},
                  {m_out[1].rj, m_out[1].rk, m_out[1].rd, m_out[1].en, m_out[1].ld});
            check("l1_data", {out_data10, out_data11}, {m_out[1].a, m_out[1].b});
        end
`ifdef RF_EXE_STALL_CNT_EN
        check("stall_cnt", stall_cnt, m_cnt);
`endif
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic run_cycle(input bit r, input bit f, input bit ordy, output bit acc);
        bit       adv, lu, dep, rdy;
        bit [1:0] issue;
        rst = r; flush = f; out_ready = ordy;
        drive();
        #1;
        adv = (!m_out[0].v && !m_out[1].v) || ordy;
        lu  = 1'b0;
        for (int l = 0; l < 2; l++)
            if (in_l[l].v && (!m_rest || l == 1) &&
                (waits_on_load(in_l[l].rj) || waits_on_load(in_l[l].rk)))
                lu = 1'b1;
        dep = !m_rest && in_l[0].v && in_l[1].v && in_l[0].en && in_l[0].rd != 5'd0 &&
              (in_l[1].rj == in_l[0].rd || in_l[1].rk == in_l[0].rd);
        rdy = !r && !f && adv && !lu && !dep && (in_l[0].v || in_l[1].v);
        check("in_ready", in_ready, rdy);
        acc = rdy;
        @(posedge clk);
        if (r) begin
            m_out[0] = '0; m_out[1] = '0; m_rest = 1'b0; m_cnt = 0;
        end else if (f) begin
            m_out[0].v = 1'b0; m_out[1].v = 1'b0; m_rest = 1'b0;
        end else if (adv) begin
            if (lu) begin
                m_out[0].v = 1'b0; m_out[1].v = 1'b0; m_cnt++;
            end else begin
                issue = m_rest ? 2'b10 : (dep ? 2'b01 : 2'b11);
                for (int l = 0; l < 2; l++)
                    if (issue[l]) m_out[l] = in_l[l];
                    else m_out[l].v = 1'b0;
                m_rest = dep;
            end
        end
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    initial begin
        bit acc, r, f, ordy, newpair;
        in_l[0] = '0; in_l[1] = '0;
        m_out[0] = '0; m_out[1] = '0; m_rest = 1'b0; m_cnt = 0;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive();
        @(negedge clk);

        in_l[0] = rnd_lane(); in_l[1] = rnd_lane();
        run_cycle(1, 0, 1, acc);
        run_cycle(1, 1, 0, acc);
        check("rst_fields", {out_eu0_valid, out_eu1_valid, out_eu0_rj, out_eu0_rk, out_eu0_rd,
                             out_eu1_rj, out_eu1_rk, out_eu1_rd, out_eu0_en, out_eu1_en,
                             out_eu0_load, out_eu1_load}, '0);
        check("rst_data", {out_data00 | out_data01 | out_data10 | out_data11}, '0);

        // independent pair
        in_l[0] = mk(1, 1, 2, 5, 1, 0); in_l[1] = mk(1, 6, 6, 9, 1, 0);
        run_cycle(0, 0, 1, acc);
        // intra-pair RAW: two cycles on the held pair
        in_l[0] = mk(1, 1, 2, 3, 1, 0); in_l[1] = mk(1, 3, 4, 10, 1, 0);
        run_cycle(0, 0, 1, acc);
        run_cycle(0, 0, 1, acc);
        // load-use on r7
        in_l[0] = mk(1, 1, 2, 7, 1, 1); in_l[1] = mk(0, 0, 0, 0, 0, 0);
        run_cycle(0, 0, 1, acc);
        in_l[0] = mk(1, 1, 2, 11, 1, 0); in_l[1] = mk(1, 4, 7, 12, 1, 0);
        run_cycle(0, 0, 1, acc);
        run_cycle(0, 0, 1, acc);
        // backpressure
        in_l[0] = mk(1, 1, 1, 13, 1, 0); in_l[1] = mk(1, 2, 2, 14, 0, 0);
        run_cycle(0, 0, 0, acc);
        run_cycle(0, 0, 0, acc);
        run_cycle(0, 0, 0, acc);
        run_cycle(0, 0, 1, acc);
        // flush during split
        in_l[0] = mk(1, 1, 2, 6, 1, 0); in_l[1] = mk(1, 2, 6, 15, 1, 0);
        run_cycle(0, 0, 1, acc);
        run_cycle(0, 1, 1, acc);
        // rd=r0 load never stalls an r0 consumer
        in_l[0] = mk(1, 0, 0, 0, 1, 1); in_l[1] = mk(0, 0, 0, 0, 0, 0);
        run_cycle(0, 0, 1, acc);
        in_l[0] = mk(1, 0, 0, 4, 1, 0); in_l[1] = mk(1, 0, 5, 8, 1, 0);
        run_cycle(0, 0, 1, acc);

        newpair = 1'b1;
        repeat (3000) begin
            if (newpair) begin
                in_l[0] = rnd_lane();
                in_l[1] = rnd_lane();
            end
            r    = ($urandom_range(0, 199) == 0);
            f    = ($urandom_range(0, 19) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            run_cycle(r, f, ordy, acc);
            newpair = acc || r || f;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
